// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and owner constants for the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
endpackage

// File: rtl/mem_arbiter_timeout_cnt.sv
// arb_timeout_cnt: per-transfer cycle counter that saturates at its expiry value
module arb_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (reset || clear_i) cnt_q <= '0;
    else if (enable_i && cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
  end
  assign expire = cnt_q == LAST;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between fetch and data requesters
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic              iGnt,
  output logic              iRValid,
  output logic [DATA_W-1:0] iRData,
  output logic              iErr,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWData,
  input  logic [3:0]        dBe,
  output logic              dGnt,
  output logic              dRValid,
  output logic [DATA_W-1:0] dRData,
  output logic              dErr,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  output logic [3:0]        memBe,
  input  logic              memRdy,
  input  logic              memRValid,
  input  logic [DATA_W-1:0] memRData,
  output logic              busy,
  output logic              owner
);
  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d, we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]        be_q, be_d;
  logic              pick, clr, en, expire;
  arb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (clr),
    .enable_i (en),
    .expire   (expire)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    clr     = 1'b0;
    iGnt    = 1'b0;
    dGnt    = 1'b0;
    pick    = (iReq && dReq) ? ~owner_q : dReq;
    en      = state_q == ISSUE || state_q == WAIT;
    case (state_q)
      IDLE: if (iReq || dReq) begin
        state_d = ISSUE;
        owner_d = pick;
        clr     = 1'b1;
        iGnt    = pick == OWN_I;
        dGnt    = pick == OWN_D;
        we_d    = pick == OWN_D && dWe;
        addr_d  = pick == OWN_D ? dAddr : iAddr;
        wdata_d = pick == OWN_D ? dWData : '0;
        be_d    = pick == OWN_D ? dBe : 4'hF;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      ISSUE: if (memRdy || expire) begin
        // a write completes on acceptance; a read still waits for its data
        state_d = (!memRdy || we_q) ? RESP : WAIT;
        rdata_d = '0;
        err_d   = !memRdy;
      end
      WAIT: if (memRValid || expire) begin
        state_d = RESP;
        rdata_d = memRValid ? memRData : '0;
        err_d   = !memRValid;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    memReq   = state_q == ISSUE;
    memWe    = we_q;
    memAddr  = addr_q;
    memWData = wdata_q;
    memBe    = be_q;
    busy     = state_q != IDLE;
    owner    = owner_q;
    iRValid  = state_q == RESP && owner_q == OWN_I;
    dRValid  = state_q == RESP && owner_q == OWN_D;
    iRData   = iRValid ? rdata_q : '0;
    dRData   = dRValid ? rdata_q : '0;
    iErr     = iRValid && err_q;
    dErr     = dRValid && err_q;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant order, handshake timing, timeout and reset behaviour
module tb_mem_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        iReq = 1'b0, dReq = 1'b0, dWe = 1'b0, memRdy = 1'b0, memRValid = 1'b0;
  logic [31:0] iAddr = '0, dAddr = '0, dWData = '0, memRData = '0;
  logic [3:0]  dBe = '0;
  logic        iGnt, iRValid, iErr, dGnt, dRValid, dErr, memReq, memWe, busy, owner;
  logic [31:0] iRData, dRData, memAddr, memWData;
  logic [3:0]  memBe;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .iReq(iReq), .iAddr(iAddr), .iGnt(iGnt), .iRValid(iRValid), .iRData(iRData), .iErr(iErr),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWData(dWData), .dBe(dBe),
    .dGnt(dGnt), .dRValid(dRValid), .dRData(dRData), .dErr(dErr),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData), .memBe(memBe),
    .memRdy(memRdy), .memRValid(memRValid), .memRData(memRData),
    .busy(busy), .owner(owner)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic nx;
    @(negedge clk);
  endtask
  task automatic do_reset;
    nx; reset = 1'b1;
    nx; reset = 1'b0;
  endtask
  task automatic run_tmo(input bit hit);
    iReq = 1'b1; iAddr = 32'h400; memRdy = 1'b1; #1;
    chk("tmo_gnt", iGnt, 1);
    for (int c = 1; c <= 15; c++) begin
      nx; iReq = 1'b0;
      if (hit && c == 15) begin memRValid = 1'b1; memRData = 32'hCAFE0001; end
      #1; chk("tmo_quiet", iRValid, 0);
    end
    nx; memRValid = 1'b0; memRData = '0; #1;
    chk("tmo_rvalid", iRValid, 1);
    chk("tmo_err", iErr, hit ? 0 : 1);
    chk("tmo_rdata", iRData, hit ? 32'hCAFE0001 : 32'h0);
    chk("tmo_memreq_resp", memReq, 0);
    nx; #1;
    chk("tmo_memreq_after", memReq, 0);
    chk("tmo_rvalid_after", iRValid, 0);
    chk("tmo_idle", busy, 0);
  endtask
  initial begin
    nx; #1;
    chk("rst_igntdgnt", {iGnt, dGnt}, 0);
    chk("rst_rvalid", {iRValid, dRValid, iErr, dErr}, 0);
    chk("rst_rdata", iRData | dRData, 0);
    chk("rst_memreq", {memReq, memWe, memBe}, 0);
    chk("rst_memaddr", memAddr, 0);
    chk("rst_memwdata", memWData, 0);
    chk("rst_busy_owner", {busy, owner}, 0);
    reset = 1'b0;
    // basic fetch read
    nx; iReq = 1'b1; iAddr = 32'h100; memRdy = 1'b1; #1;
    chk("rd_ignt", iGnt, 1);
    chk("rd_dgnt", dGnt, 0);
    nx; iReq = 1'b0; #1;
    chk("rd_memreq", memReq, 1);
    chk("rd_memaddr", memAddr, 32'h100);
    chk("rd_membe", memBe, 4'hF);
    chk("rd_memwe", memWe, 0);
    nx; memRValid = 1'b1; memRData = 32'hDEADBEEF; #1;
    chk("rd_wait_memreq", memReq, 0);
    chk("rd_wait_rvalid", iRValid, 0);
    nx; memRValid = 1'b0; memRData = '0; #1;
    chk("rd_rvalid", iRValid, 1);
    chk("rd_rdata", iRData, 32'hDEADBEEF);
    chk("rd_err", iErr, 0);
    chk("rd_drvalid", dRValid, 0);
    nx; #1;
    chk("rd_rvalid_drop", iRValid, 0);
    chk("rd_idle", busy, 0);
    // round-robin ties
    do_reset;
    memRdy = 1'b1; memRValid = 1'b1; memRData = 32'h55;
    dWe = 1'b1; dAddr = 32'h300; dWData = 32'hAA; dBe = 4'hF;
    for (int k = 0; k < 4; k++) begin
      nx; iReq = 1'b1; dReq = 1'b1; iAddr = k; #1;
      chk("tie_dgnt", dGnt, (k % 2 == 0) ? 1 : 0);
      chk("tie_ignt", iGnt, (k % 2 == 0) ? 0 : 1);
      nx; iReq = 1'b0; dReq = 1'b0;
      if (k % 2 == 0) begin
        nx; #1;
        chk("tie_drvalid", dRValid, 1);
        chk("tie_owner_d", owner, 1);
      end else begin
        nx; nx; #1;
        chk("tie_irvalid", iRValid, 1);
        chk("tie_irdata", iRData, 32'h55);
        chk("tie_owner_i", owner, 0);
      end
    end
    memRValid = 1'b0; memRData = '0; memRdy = 1'b0;
    // delayed-accept store
    nx; dReq = 1'b1; dWe = 1'b1; dAddr = 32'h200; dWData = 32'h12345678; dBe = 4'b0011; #1;
    chk("wr_dgnt", dGnt, 1);
    nx; dReq = 1'b0; dAddr = 32'hFFF; dWData = '0; dBe = 4'hF; #1;
    chk("wr_memreq1", memReq, 1);
    chk("wr_addr1", memAddr, 32'h200);
    chk("wr_wdata1", memWData, 32'h12345678);
    chk("wr_be1", memBe, 4'b0011);
    chk("wr_we1", memWe, 1);
    nx; #1;
    chk("wr_memreq2", memReq, 1);
    chk("wr_addr2", memAddr, 32'h200);
    chk("wr_wdata2", memWData, 32'h12345678);
    chk("wr_be2", memBe, 4'b0011);
    nx; memRdy = 1'b1; #1;
    chk("wr_memreq3", memReq, 1);
    chk("wr_rvalid_early", dRValid, 0);
    nx; memRdy = 1'b0; #1;
    chk("wr_rvalid", dRValid, 1);
    chk("wr_rdata", dRData, 0);
    chk("wr_err", dErr, 0);
    chk("wr_memreq_resp", memReq, 0);
    // timeout, then completion on the expiry cycle
    nx;
    run_tmo(1'b0);
    run_tmo(1'b1);
    // reset while waiting for read data
    nx; dReq = 1'b1; dWe = 1'b0; dAddr = 32'h500; memRdy = 1'b1; memRValid = 1'b0; #1;
    chk("rst_dgnt", dGnt, 1);
    nx; dReq = 1'b0; #1;
    chk("rst_issue", memReq, 1);
    chk("rst_owner_d", owner, 1);
    nx; reset = 1'b1; #1;
    chk("rst_wait_busy", busy, 1);
    nx; reset = 1'b0; dReq = 1'b1; dWe = 1'b1; dAddr = 32'h600; dWData = 32'h9; dBe = 4'hF; #1;
    chk("rstw_busy", busy, 0);
    chk("rstw_memreq", memReq, 0);
    chk("rstw_owner", owner, 0);
    chk("rstw_rvalid", {iRValid, dRValid}, 0);
    chk("rstw_dgnt", dGnt, 1);
    nx; dReq = 1'b0; #1;
    chk("rstw_memaddr", memAddr, 32'h600);
    chk("rstw_memreq2", memReq, 1);
    nx; #1;
    chk("rstw_drvalid", dRValid, 1);
    // stray memRValid outside WAIT
    nx; memRdy = 1'b0; memRValid = 1'b1; memRData = 32'hBAD; #1;
    chk("stray_idle_busy", busy, 0);
    chk("stray_idle_rv", {iRValid, dRValid}, 0);
    nx; #1;
    chk("stray_idle_busy2", busy, 0);
    chk("stray_idle_rv2", {iRValid, dRValid}, 0);
    nx; iReq = 1'b1; iAddr = 32'h700; #1;
    chk("stray_ignt", iGnt, 1);
    nx; iReq = 1'b0; #1;
    chk("stray_issue1", memReq, 1);
    nx; memRdy = 1'b1; #1;
    chk("stray_issue2", memReq, 1);
    nx; memRdy = 1'b0; memRValid = 1'b0; #1;
    chk("stray_wait_memreq", memReq, 0);
    chk("stray_wait_rv", iRValid, 0);
    chk("stray_wait_busy", busy, 1);
    nx; memRValid = 1'b1; memRData = 32'h77; #1;
    chk("stray_wait_rv2", iRValid, 0);
    nx; memRValid = 1'b0; memRData = '0; #1;
    chk("stray_rvalid", iRValid, 1);
    chk("stray_rdata", iRData, 32'h77);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
